// File: rtl/csa_pkg.sv
// Shared encodings and helpers for the pipelined carry-select adder.
package csa_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Subtract is a + ~b + 1, so an active-high borrow-in becomes an inverted carry-in.
  function automatic logic eff_carry_in(input logic op_sub, input logic c_in);
    return (op_sub == OP_SUB) ? ~c_in : c_in;
  endfunction

endpackage

// File: rtl/csa_block.sv
// Combinational BLOCK_W-bit dual-result adder: both candidate sums for carry-in 0 and 1.
module csa_block #(
  parameter int BLOCK_W = 4
) (
  input  logic [BLOCK_W-1:0] a,
  input  logic [BLOCK_W-1:0] b,
  output logic [BLOCK_W-1:0] sum0,
  output logic               carry0,
  output logic [BLOCK_W-1:0] sum1,
  output logic               carry1
);

  assign {carry0, sum0} = {1'b0, a} + {1'b0, b};
  assign {carry1, sum1} = {1'b0, a} + {1'b0, b} + (BLOCK_W + 1)'(1);

endmodule

// File: rtl/csa_pipe_adder.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready on both sides.
// Optional signed-overflow output enabled by defining OVERFLOW_FLAG_EN.
module csa_pipe_adder
  import csa_pkg::*;
#(
  parameter  int BLOCK_W  = 4,
  parameter  int N_BLOCKS = 2,
  localparam int WIDTH    = BLOCK_W * N_BLOCKS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  typedef struct packed {
    logic [BLOCK_W-1:0] sum0;
    logic [BLOCK_W-1:0] sum1;
    logic               carry0;
    logic               carry1;
  } csa_blk_t;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             accept;
  logic             advance1;
  logic             advance2;
  logic             v1;
  logic             cin_q;
  csa_blk_t         blk_d [N_BLOCKS];
  csa_blk_t         blk_q [N_BLOCKS];
  logic [WIDTH-1:0] s_next;
  logic             c_next;

  assign b_eff   = (op_sub == OP_SUB) ? ~b : b;
  assign cin_eff = eff_carry_in(op_sub, c_in);

  assign advance2 = !out_valid || out_ready;
  assign advance1 = !v1 || advance2;
  assign in_ready = advance1;
  assign accept   = in_valid && in_ready;

  for (genvar k = 0; k < N_BLOCKS; k++) begin : g_blk
    csa_block #(
      .BLOCK_W(BLOCK_W)
    ) u_blk (
      .a      (a[k*BLOCK_W +: BLOCK_W]),
      .b      (b_eff[k*BLOCK_W +: BLOCK_W]),
      .sum0   (blk_d[k].sum0),
      .carry0 (blk_d[k].carry0),
      .sum1   (blk_d[k].sum1),
      .carry1 (blk_d[k].carry1)
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
    end else if (advance1) begin
      v1 <= accept;
    end
  end

  // Stage-1 data only moves on an accepted beat, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      blk_q <= blk_d;
      cin_q <= cin_eff;
    end
  end

`ifdef OVERFLOW_FLAG_EN
  logic msb_x_q;

  // a^b_eff at the MSB; XOR with the final MSB sum recovers the carry into the MSB.
  always_ff @(posedge clk) begin
    if (accept) begin
      msb_x_q <= a[WIDTH-1] ^ b_eff[WIDTH-1];
    end
  end
`endif

  always_comb begin : resolve
    logic sel;
    sel    = cin_q;
    s_next = '0;
    for (int k = 0; k < N_BLOCKS; k++) begin
      s_next[k*BLOCK_W +: BLOCK_W] = sel ? blk_q[k].sum1 : blk_q[k].sum0;
      sel = sel ? blk_q[k].carry1 : blk_q[k].carry0;
    end
    c_next = sel;
  end

  // Result registers only load with a valid beat, keeping outputs X-free and stable in stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s         <= '0;
      c_out     <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovf       <= 1'b0;
`endif
    end else if (advance2) begin
      out_valid <= v1;
      if (v1) begin
        s     <= s_next;
        c_out <= c_next;
`ifdef OVERFLOW_FLAG_EN
        ovf   <= msb_x_q ^ s_next[WIDTH-1] ^ c_next;
`endif
      end
    end
  end

endmodule
